// File: rtl/mem_if.sv
// mem_if: request/response bus between a requester and data_mem_ctrl
// Signals: req_valid/req_ready handshake, req_write, req_size, req_signed, req_addr, req_wdata;
//          resp_valid one-cycle strobe with resp_rdata and resp_fault
interface mem_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised little-endian data memory with one-outstanding valid/ready access
// Ports: clk       - clock, all state changes on posedge
//        reset     - asynchronous active-high reset
//        bus       - mem_if.slave: request (valid/ready, write, size, signed, addr, wdata)
//                    and response (one-cycle resp_valid with resp_rdata, resp_fault)
module data_mem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic clk,
    input  logic reset,
    mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              w_q, sg_q;
    logic [1:0]        sz_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              accept, enter_resp;
    logic              e_w, e_sg;
    logic [1:0]        e_sz;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              fault;
    logic [31:0]       word, ld, wpat;
    logic [3:0]        wmask;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       mem [DEPTH];

    assign accept      = state == IDLE && bus.req_valid;
    assign enter_resp  = state_nx == RESP && state != RESP;
    assign bus.req_ready = state == IDLE;

    // With LATENCY = 1 the commit edge is the accept edge, so the live bus
    // fields are used there; otherwise the latched request is.
    assign e_w     = state == IDLE ? bus.req_write  : w_q;
    assign e_sg    = state == IDLE ? bus.req_signed : sg_q;
    assign e_sz    = state == IDLE ? bus.req_size   : sz_q;
    assign e_addr  = state == IDLE ? bus.req_addr   : addr_q;
    assign e_wdata = state == IDLE ? bus.req_wdata  : wdata_q;

    assign idx  = e_addr[IDX_W+1:2];
    assign lane = e_addr[1:0];

    assign fault = ((e_addr >> (IDX_W + 2)) != '0)
                || e_sz == 2'd3
                || (e_sz == 2'd1 && lane[0])
                || (e_sz == 2'd2 && lane != 2'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = LATENCY == 1 ? RESP : WAIT;
            cnt_nx   = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
        end else if (state == WAIT) begin
            state_nx = cnt == 4'd0 ? RESP : WAIT;
            cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
        end else if (state == RESP) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        word   = mem[idx];
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = lane[1] ? word[31:16] : word[15:0];
        ld     = e_sz == 2'd0 ? {{24{e_sg & byte_v[7]}}, byte_v}
               : e_sz == 2'd1 ? {{16{e_sg & half_v[15]}}, half_v}
               : word;
        wpat   = e_sz == 2'd0 ? {4{e_wdata[7:0]}}
               : e_sz == 2'd1 ? {2{e_wdata[15:0]}}
               : e_wdata;
        wmask  = e_sz == 2'd0 ? 4'b0001 << lane
               : e_sz == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011)
               : 4'b1111;
    end

    // The array has no reset; a request accepted while reset is high must not write.
    always_ff @(posedge clk)
        if (enter_resp && e_w && !fault && !reset)
            for (int i = 0; i < 4; i++)
                if (wmask[i])
                    mem[idx][8*i +: 8] <= wpat[8*i +: 8];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            w_q            <= 1'b0;
            sg_q           <= 1'b0;
            sz_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_fault <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            bus.resp_valid <= enter_resp;
            if (accept) begin
                w_q     <= bus.req_write;
                sg_q    <= bus.req_signed;
                sz_q    <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                bus.resp_rdata <= (e_w || fault) ? '0 : ld;
                bus.resp_fault <= fault;
            end
        end
endmodule
